// File: rtl/decoder_grant_arbiter_pkg.sv
// Shared constants and types for the round-robin grant arbiter and its decoder.
package decoder_grant_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  typedef logic [NUM_REQ-1:0] reqVec_t;
  typedef logic [SEL_W-1:0]   sel_t;

endpackage

// File: rtl/decoder_grant_arbiter_dec.sv
// Decoder_8: registered enable/select into a one-hot grant vector.
module decoder_grant_arbiter_dec
  import decoder_grant_arbiter_pkg::*;
(
  input  logic    en,
  input  sel_t    sel,
  output reqVec_t oh
);

  always_comb begin
    oh = '0;
    if (en) oh[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with hold-time watchdog and a
// one-cycle bus turnaround between owners.
//
// state | meaning
// IDLE  | no owner; arbitrate when arb_en and any request
// GRANT | grant_sel owns the bus; watchdog counting
// TURN  | one-cycle turnaround gap after release or timeout
module decoder_grant_arbiter
  import decoder_grant_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               sysclk,
  input  logic               sysrst,
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] req,
  output logic               grant_en,
  output logic [SEL_W-1:0]   grant_sel,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic               busy,
  output logic               timeout_pulse
);

  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic             WD_ON    = (MAX_HOLD != 0);

  logic [1:0]       state;
  sel_t             rrPtr;
  logic [CNT_W-1:0] holdCnt;
  sel_t             winner;
  logic             ownerReq;
  logic             otherReq;
  logic             timeoutHit;

  // Rotate so rrPtr+1 lands at bit 0, take the lowest set bit, then undo the rotation.
  function automatic sel_t rrPick(input reqVec_t r, input sel_t ptr);
    logic [2*NUM_REQ-1:0] dbl;
    reqVec_t              rot;
    sel_t                 start;
    sel_t                 off;
    start = ptr + 1'b1;
    dbl   = {r, r} >> start;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    return start + off;
  endfunction

  assign winner     = rrPick(req, rrPtr);
  assign ownerReq   = req[grant_sel];
  assign otherReq   = |(req & ~grant_oh);
  assign timeoutHit = WD_ON && (holdCnt == HOLD_LIM) && otherReq;
  assign busy       = (state != IDLE);

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state         <= IDLE;
      grant_en      <= 1'b0;
      grant_sel     <= '0;
      rrPtr         <= sel_t'(NUM_REQ - 1);
      holdCnt       <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en && |req) begin
            state     <= GRANT;
            grant_en  <= 1'b1;
            grant_sel <= winner;
            rrPtr     <= winner;
            holdCnt   <= '0;
          end
        end
        GRANT: begin
          // Release wins over a coincident timeout, so no pulse in that case.
          if (!ownerReq) begin
            state    <= TURN;
            grant_en <= 1'b0;
          end else if (timeoutHit) begin
            state         <= TURN;
            grant_en      <= 1'b0;
            timeout_pulse <= 1'b1;
          end else if (holdCnt != HOLD_LIM) begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          grant_en <= 1'b0;
        end
      endcase
    end
  end

  decoder_grant_arbiter_dec u_grant_dec (
    .en  (grant_en),
    .sel (grant_sel),
    .oh  (grant_oh)
  );

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Directed and randomized checks of the round-robin grant arbiter against a behavioural model.
module tb_decoder_grant_arbiter;

  localparam int MAXH = 4;

  logic       sysclk = 1'b0;
  logic       sysrst;
  logic       arb_en;
  logic [7:0] req;
  logic       grant_en;
  logic [2:0] grant_sel;
  logic [7:0] grant_oh;
  logic       busy;
  logic       timeout_pulse;

  int checks = 0;
  int errors = 0;

  // model: phase 0 = no owner, 1 = owner holds, 2 = turnaround
  int         mPhase;
  logic [2:0] mSel;
  logic [2:0] mPtr;
  int         mHeld;
  logic       mTo;

  int gap;
  int hi;
  int tos;
  int expSel [4] = '{0, 7, 0, 7};

  decoder_grant_arbiter #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
    .sysclk        (sysclk),
    .sysrst        (sysrst),
    .arb_en        (arb_en),
    .req           (req),
    .grant_en      (grant_en),
    .grant_sel     (grant_sel),
    .grant_oh      (grant_oh),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = 0;
    mSel   = 3'd0;
    mPtr   = 3'd7;
    mHeld  = 0;
    mTo    = 1'b0;
  endtask

  task automatic modelClock(input logic [7:0] r, input logic en);
    logic [2:0] idx;
    logic       found;
    mTo = 1'b0;
    case (mPhase)
      0: begin
        if (en && r != 8'h00) begin
          found = 1'b0;
          for (int k = 1; k <= 8; k++) begin
            idx = mPtr + 3'(k);
            if (r[idx] && !found) begin
              found = 1'b1;
              mSel  = idx;
            end
          end
          mPtr   = mSel;
          mHeld  = 0;
          mPhase = 1;
        end
      end
      1: begin
        if (!r[mSel]) mPhase = 2;
        else if (mHeld == MAXH - 1 && (r & ~(8'h01 << mSel)) != 8'h00) begin
          mPhase = 2;
          mTo    = 1'b1;
        end else if (mHeld < MAXH - 1) mHeld++;
      end
      default: mPhase = 0;
    endcase
  endtask

  task automatic checkOutputs();
    chk("grant_en", 32'(grant_en), (mPhase == 1) ? 32'd1 : 32'd0);
    chk("grant_sel", 32'(grant_sel), 32'(mSel));
    chk("grant_oh", 32'(grant_oh), (mPhase == 1) ? 32'(8'h01 << mSel) : 32'd0);
    chk("busy", 32'(busy), (mPhase != 0) ? 32'd1 : 32'd0);
    chk("timeout_pulse", 32'(timeout_pulse), 32'(mTo));
    chk("onehot0", 32'($onehot0(grant_oh)), 32'd1);
    chk("oh_when_off", 32'(!grant_en && grant_oh != 8'h00), 32'd0);
  endtask

  task automatic step();
    @(posedge sysclk);
    if (sysrst) modelReset();
    else modelClock(req, arb_en);
    #1;
    checkOutputs();
  endtask

  task automatic doReset();
    req    = 8'h00;
    sysrst = 1'b1;
    step();
    step();
    sysrst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    modelReset();
    sysrst = 1'b1;
    arb_en = 1'b1;
    req    = 8'hFF;

    // reset with every request high
    step();
    step();
    chk("rst_oh", 32'(grant_oh), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sysrst = 1'b0;
    step();
    chk("first_sel", 32'(grant_sel), 32'd0);
    chk("first_en", 32'(grant_en), 32'd1);

    // round robin between 0 and 7
    doReset();
    req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      gap = 0;
      step();
      req = 8'h81;
      while (!grant_en && gap < 10) begin
        gap++;
        step();
      end
      chk("rr_granted", 32'(grant_en), 32'd1);
      chk("rr_sel", 32'(grant_sel), 32'(expSel[g]));
      if (g > 0) chk("rr_gap", 32'(gap), 32'd2);
      step();
      step();
      req = 8'h81 & ~(8'h01 << grant_sel);
    end

    // wrap-around from rr_ptr = 6
    doReset();
    req = 8'h40;
    step();
    chk("wrap_first", 32'(grant_sel), 32'd6);
    req = 8'h00;
    step();
    step();
    req = 8'h03;
    step();
    chk("wrap_sel0", 32'(grant_sel), 32'd0);
    req = 8'h02;
    step();
    step();
    step();
    chk("wrap_sel1", 32'(grant_sel), 32'd1);
    chk("wrap_en1", 32'(grant_en), 32'd1);

    // watchdog with a competing requester
    doReset();
    req = 8'h24;
    step();
    chk("wd_first", 32'(grant_sel), 32'd2);
    hi = 1;
    while (grant_en && hi < 20) begin
      step();
      if (grant_en) hi++;
    end
    chk("wd_len", 32'(hi), 32'd4);
    chk("wd_pulse", 32'(timeout_pulse), 32'd1);
    step();
    chk("wd_pulse_end", 32'(timeout_pulse), 32'd0);
    step();
    chk("wd_next", 32'(grant_sel), 32'd5);
    req = 8'h04;
    step();
    step();
    step();
    chk("wd_solo_sel", 32'(grant_sel), 32'd2);
    tos = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (timeout_pulse || !grant_en) tos++;
    end
    chk("wd_solo_keep", 32'(tos), 32'd0);

    // arb_en gating
    doReset();
    arb_en = 1'b0;
    req    = 8'h10;
    step();
    step();
    step();
    chk("arb_off", 32'(grant_oh), 32'd0);
    arb_en = 1'b1;
    step();
    chk("arb_on", 32'(grant_oh), 32'h10);
    arb_en = 1'b0;
    step();
    step();
    step();
    chk("arb_drop_keep", 32'(grant_oh), 32'h10);

    // asynchronous reset between edges
    @(negedge sysclk);
    sysrst = 1'b1;
    #1;
    modelReset();
    chk("async_en", 32'(grant_en), 32'd0);
    chk("async_oh", 32'(grant_oh), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    checkOutputs();
    step();
    sysrst = 1'b0;
    arb_en = 1'b1;

    // randomized traffic with sticky requests
    req = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      arb_en = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
